// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth-table capture stage.
package truth_table_pkg;

  typedef enum logic [1:0] {StIdle, StHold, StSample, StFinish} state_e;

  localparam int unsigned DefNIn        = 4;
  localparam int unsigned DefHoldCycles = 2;

  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_capture_if.sv
// Stimulus/capture bus between the capture stage and its environment.
interface truth_table_capture_if #(
  parameter int unsigned N_IN = 4
);
  logic                  start;
  logic                  abort;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  d;
  logic                  f_in;
  logic                  busy;
  logic                  done;
  logic [2**N_IN-1:0]    table_out;
  logic [N_IN:0]         ones_count;

  modport master (
    input  start, abort, f_in,
    output a, b, c, d, busy, done, table_out, ones_count
  );

  modport slave (
    output start, abort, f_in,
    input  a, b, c, d, busy, done, table_out, ones_count
  );

endinterface

// File: rtl/hold_timer.sv
// Loadable up-counter; term flags that the current vector has been held HOLD_CYCLES edges.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (load) begin
      cnt_d = 8'd1;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == 8'(HOLD_CYCLES));

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all input vectors of a combinational block and captures its truth table and popcount.
module truth_table_capture
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN        = DefNIn,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_capture_if.master bus
);

  localparam int unsigned VecCount = vec_count(N_IN);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [VecCount-1:0]   table_q, table_d;
  logic [N_IN:0]         ones_q, ones_d;
  logic                  tmr_load, tmr_clr, tmr_en, tmr_term;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    table_d  = table_q;
    ones_d   = ones_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StHold;
          idx_d    = '0;
          table_d  = '0;
          ones_d   = '0;
          tmr_load = 1'b1;
        end
      end
      StHold: begin
        if (bus.abort) begin
          state_d = StIdle;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          state_d = StSample;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StSample: begin
        // Abort outranks the sample so a cancelled sweep never leaves a partial table.
        if (bus.abort) begin
          state_d = StIdle;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
          tmr_clr = 1'b1;
        end else begin
          table_d[idx_q] = bus.f_in;
          ones_d         = ones_q + (N_IN + 1)'(bus.f_in);
          if (idx_q == {N_IN{1'b1}}) begin
            state_d = StFinish;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
            state_d  = StHold;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        idx_d   = '0;
        tmr_clr = 1'b1;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  // Outputs come straight from state registers; f_in never reaches them combinationally.
  assign bus.a          = idx_q[N_IN-1];
  assign bus.b          = idx_q[N_IN-2];
  assign bus.c          = idx_q[N_IN-3];
  assign bus.d          = idx_q[N_IN-4];
  assign bus.busy       = (state_q == StHold) || (state_q == StSample);
  assign bus.done       = (state_q == StFinish);
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential stimulus-and-capture stage that wraps a 4-input combinational function block.
- Upstream role: sweeps every input vector {a,b,c,d} from 0000 to 1111 and drives the function block.
- Downstream role: samples the function output f after a settle window and assembles the full truth table plus a count of ones.
- Gives hardware self-check of function blocks without a free-running testbench sweep.

Parameters:
- N_IN, 4: number of function inputs; vector index width.
- HOLD_CYCLES, 2: cycles each vector is held before f is sampled; legal range 1..255.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; accepted only in IDLE.
- abort  in  1  synchronous sweep cancel; honoured only while busy.
- a  out  1  vector bit 3 (MSB) to function block.
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0 (LSB).
- f_in  in  1  function block output.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the full table is valid.
- table_out  out  2**N_IN  table_out[idx] = f for idx = {a,b,c,d}.
- ones_count  out  N_IN+1  number of ones in table_out.

Behaviour:
- Reset (async, rst=1): state IDLE, a=b=c=d=0, busy=0, done=0, table_out=0, ones_count=0, hold counter=0. Takes effect immediately, including mid-sweep; no done is produced for the interrupted sweep.
- FSM states: IDLE, HOLD, SAMPLE, FINISH.
- IDLE:
  - start=1 at edge E0 -> HOLD, idx=0, busy=1, table_out=0, ones_count=0, hold counter=1.
  - Vector 0000 is driven from E0.
- HOLD:
  - Counter increments each edge.
  - When counter reaches HOLD_CYCLES -> SAMPLE.
  - With HOLD_CYCLES=1, HOLD lasts zero extra cycles; the sample occurs on the edge after E0.
- SAMPLE (single edge):
  - table_out[idx] <= f_in.
  - ones_count increments by f_in.
  - If idx = 2**N_IN-1 -> FINISH; otherwise idx+1, counter=1, -> HOLD.
- Per-vector timing: each vector is stable on a,b,c,d for exactly HOLD_CYCLES+1 cycles, and f_in is sampled on the last of those edges.
- FINISH (one cycle): done=1, busy=0 on the same cycle, then -> IDLE.
  - In IDLE, a,b,c,d return to 0000.
  - table_out and ones_count hold until the next accepted start.
- Total latency: start edge E0 to done high = 2**N_IN*(HOLD_CYCLES+1) cycles (48 at defaults).
- start while busy or in FINISH: ignored, no restart, no effect on table.
- abort=1 while busy:
  - Next edge -> IDLE, busy=0, no done pulse.
  - Vector returns to 0000; table_out and ones_count cleared to 0.
  - abort has priority over a same-cycle SAMPLE.
  - abort in IDLE has no effect.
- start and abort together in IDLE: start wins (abort is ignored in IDLE).
- Widths:
  - idx is N_IN bits; wrap never occurs because FINISH is taken at all-ones.
  - ones_count is N_IN+1 bits so 16 fits without overflow.
- All outputs are registered; no combinational path from f_in to any output.

Decomposition:
- Shared package truth_table_pkg:
  - state enum (IDLE, HOLD, SAMPLE, FINISH);
  - default N_IN and HOLD_CYCLES constants;
  - function vec_count(N_IN) = 2**N_IN.
- One sub-module, hold_timer:
  - loadable up-counter with a terminal flag at HOLD_CYCLES;
  - async active-high reset on rst.
- Vector register, table shift/index logic and FSM stay in the top.

Test Plan:
- f_in = a&b, defaults, pulse start -> done exactly 48 cycles after the start edge; table_out=16'hF000, ones_count=4, busy low on the done cycle.
- f_in = a^b^c^d -> table_out=16'h6996, ones_count=8. Then f_in tied 0 with a second start -> table_out=16'h0000, ones_count=0.
- HOLD_CYCLES=1, f_in = d -> done after 32 cycles, table_out=16'hAAAA; each vector is held for exactly 2 cycles, checked by a monitor.
- Pulse start again at cycles 5 and 20 of a sweep -> ignored; single done at cycle 48; result identical to the undisturbed run.
- abort at cycle 10, and separately rst asserted mid-cycle at 15 -> immediate busy=0, table_out=0, ones_count=0, no done. A fresh start afterwards yields the correct 16'hF000 for a&b.
